ls_mem_ctrl: RTL

//  Load/store bus controller for the LS stage. Issues one data-memory access per LS instruction over a req/ack bus.

---
 rtl/ls_mem_ctrl_pkg.sv | 31 +++
 rtl/ls_mem_ctrl_if.sv | 23 ++
 rtl/ls_mem_ctrl_data_align.sv | 53 +++++
 rtl/ls_mem_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ls_mem_ctrl_pkg.sv
// Shared constants for the LS-stage load/store bus controller: access sizes,
// FSM state encoding, the default bus timeout and address-alignment helpers.
package ls_mem_ctrl_pkg;

  typedef logic [1:0] ls_size_t;

  localparam ls_size_t LS_SIZE_B = 2'b00;
  localparam ls_size_t LS_SIZE_H = 2'b01;
  localparam ls_size_t LS_SIZE_W = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int LS_TMO_DEFAULT = 1023;

  // Size code 11 is handled as a word everywhere.
  function automatic logic [1:0] align_lo(input ls_size_t size, input logic [1:0] lo);
    case (size)
      LS_SIZE_B: return lo;
      LS_SIZE_H: return {lo[1], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input ls_size_t size, input logic [1:0] lo);
    return align_lo(size, lo) != lo;
  endfunction

endpackage

// File: rtl/ls_mem_ctrl_if.sv
// Data-memory req/ack bus between the LS controller (master) and memory (slave).
interface ls_mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic [DATA_W/8-1:0]   bus_wstrb;
  logic                  bus_ack;
  logic [DATA_W-1:0]     bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/ls_mem_ctrl_data_align.sv
// Combinational lane steering: store strobes/replicated data, and load lane
// extraction with sign or zero extension. 32-bit bus only.
module ls_data_align
  import ls_mem_ctrl_pkg::*;
(
  input  ls_size_t    st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_strb,
  output logic [31:0] st_lane,
  input  ls_size_t    ld_size,
  input  logic [1:0]  ld_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_fmt
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_strb = 4'b1111;
    st_lane = st_data;
    case (st_size)
      LS_SIZE_B: begin
        st_strb = 4'b0001 << st_lo;
        st_lane = {4{st_data[7:0]}};
      end
      LS_SIZE_H: begin
        st_strb = st_lo[1] ? 4'b1100 : 4'b0011;
        st_lane = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_lo)
      2'd0:    ld_byte = ld_raw[7:0];
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    ld_half = ld_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
    ld_fmt  = ld_raw;
    case (ld_size)
      LS_SIZE_B: ld_fmt = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      LS_SIZE_H: ld_fmt = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default:   ;
    endcase
  end

endmodule

// File: rtl/ls_mem_ctrl.sv
// LS-stage load/store bus controller: one req/ack access per LS instruction,
// stall request while outstanding. Optional feature macro: LS_MISALIGN_TRAP_EN.
//
//   state | meaning
//   IDLE  | waiting for an LS memory instruction
//   REQ   | bus_req asserted, waiting for bus_ack or timeout
//   DROP  | instruction flushed, waiting out the ack, data discarded
//   DONE  | result in ld_data, held while the LS stage is stalled
module ls_mem_ctrl
  import ls_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = LS_TMO_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ls_valid,
  input  logic              ls_we,
  input  ls_size_t          ls_size,
  input  logic              ls_unsigned,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic              ls_stall,
  input  logic              ls_flush,
  ls_mem_ctrl_if.master     bus,
  output logic              stallreq_from_ls,
  output logic [DATA_W-1:0] ld_data,
  output logic              ls_fault,
  output logic              ls_misalign
);

  localparam int CNT_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TMO_CYC);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  ls_size_t         size_q;
  logic             uns_q;
  logic             accept;
  logic             trap;
  logic             issue;
  logic [1:0]       lo_eff;
  logic [3:0]       st_strb;
  logic [31:0]      st_lane;
  logic [31:0]      ld_fmt;

  assign accept = (state == ST_IDLE) & ls_valid & ~ls_flush;
  assign lo_eff = align_lo(ls_size, ls_addr[1:0]);

`ifdef LS_MISALIGN_TRAP_EN
  assign trap = accept & is_misaligned(ls_size, ls_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign issue            = accept & ~trap;
  assign stallreq_from_ls = issue | (state == ST_REQ) | (state == ST_DROP);

  ls_data_align u_align (
    .st_size     (ls_size),
    .st_lo       (lo_eff),
    .st_data     (ls_wdata),
    .st_strb     (st_strb),
    .st_lane     (st_lane),
    .ld_size     (size_q),
    .ld_lo       (bus.bus_addr[1:0]),
    .ld_unsigned (uns_q),
    .ld_raw      (bus.bus_rdata),
    .ld_fmt      (ld_fmt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      size_q        <= LS_SIZE_B;
      uns_q         <= 1'b0;
      ld_data       <= '0;
      ls_fault      <= 1'b0;
      ls_misalign   <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_wstrb <= '0;
    end else begin
      ls_fault    <= 1'b0;
      ls_misalign <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            state         <= ST_REQ;
            cnt           <= CNT_INIT;
            size_q        <= ls_size;
            uns_q         <= ls_unsigned;
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= ls_we;
            bus.bus_addr  <= {ls_addr[ADDR_W-1:2], lo_eff};
            bus.bus_wdata <= st_lane;
            bus.bus_wstrb <= ls_we ? st_strb : 4'b0000;
          end else if (trap) begin
            state       <= ST_DONE;
            ls_misalign <= 1'b1;
            ld_data     <= '0;
          end
        end
        ST_REQ: begin
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            if (ls_flush) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_DONE;
              if (!bus.bus_we) ld_data <= ld_fmt;
            end
          end else if (cnt == '0) begin
            // A killed instruction that also times out reports no fault.
            bus.bus_req <= 1'b0;
            if (ls_flush) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_DONE;
              ls_fault <= 1'b1;
              ld_data  <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
            if (ls_flush) state <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          if (!ls_stall || ls_flush) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
